// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder slice.
// Holds the scan-code set 2 prefix/status byte values, the modifier key codes,
// the event record layout stored in the event FIFO, the parser state type and
// the scan-code to ASCII translation helper.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // Status / ack / error bytes discarded when no prefix is pending
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    // Modifier keys (non-extended)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Event entry: {ext, brk, code[7:0], ascii[7:0]}
    localparam int unsigned EVT_W         = 18;
    localparam int unsigned EVT_EXT_BIT   = 17;
    localparam int unsigned EVT_BRK_BIT   = 16;
    localparam int unsigned EVT_CODE_LSB  = 8;
    localparam int unsigned EVT_ASCII_LSB = 0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } parse_state_e;

    // Letters come out lowercase from the table and are shifted to uppercase
    // when 'upper' is set; digits and control keys ignore 'upper'.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       ext,
                                                 input logic       upper);
        logic [7:0] r;
        r = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: r = 8'h61; 8'h32: r = 8'h62; 8'h21: r = 8'h63;
                8'h23: r = 8'h64; 8'h24: r = 8'h65; 8'h2B: r = 8'h66;
                8'h34: r = 8'h67; 8'h33: r = 8'h68; 8'h43: r = 8'h69;
                8'h3B: r = 8'h6A; 8'h42: r = 8'h6B; 8'h4B: r = 8'h6C;
                8'h3A: r = 8'h6D; 8'h31: r = 8'h6E; 8'h44: r = 8'h6F;
                8'h4D: r = 8'h70; 8'h15: r = 8'h71; 8'h2D: r = 8'h72;
                8'h1B: r = 8'h73; 8'h2C: r = 8'h74; 8'h3C: r = 8'h75;
                8'h2A: r = 8'h76; 8'h1D: r = 8'h77; 8'h22: r = 8'h78;
                8'h35: r = 8'h79; 8'h1A: r = 8'h7A;
                8'h45: r = 8'h30; 8'h16: r = 8'h31; 8'h1E: r = 8'h32;
                8'h26: r = 8'h33; 8'h25: r = 8'h34; 8'h2E: r = 8'h35;
                8'h36: r = 8'h36; 8'h3D: r = 8'h37; 8'h3E: r = 8'h38;
                8'h46: r = 8'h39;
                8'h29: r = 8'h20; 8'h5A: r = 8'h0D; 8'h66: r = 8'h08;
                8'h0D: r = 8'h09; 8'h76: r = 8'h1B;
                default: r = 8'h00;
            endcase
            if (upper && (r >= 8'h61) && (r <= 8'h7A)) begin
                r = r - 8'h20;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO for decoded key events.
// Ports: clk, rst_n (async, active-low); push_i/din_i write an entry when not
// full (or when a pop happens in the same cycle); pop_i removes the head when
// not empty; dout_o shows the head, or the last popped entry while empty;
// full_o / empty_o report occupancy.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] hold_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

    // While empty the consumer keeps seeing the most recently popped entry.
    assign dout_o = empty_o ? hold_q : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_pop) begin
                hold_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder.
// Collapses E0/F0/E1 prefix sequences into single key events, tracks Shift and
// Caps Lock, translates keys to ASCII and queues events in a FWFT FIFO.
// Ports: clk, rst_n (async, active-low); rx_byte/rx_valid/rx_err from the
// frame receiver; evt_valid/evt_ready handshake with evt_code, evt_ext,
// evt_break, evt_ascii describing the head event; shift_active and caps_lock
// modifier state; overflow sticky drop flag cleared by ovf_clr.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PAUSE_LEN  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_ascii,
    output logic       shift_active,
    output logic       caps_lock,
    input  logic       ovf_clr,
    output logic       overflow
);

    localparam int unsigned CNT_W = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);
    localparam logic [CNT_W-1:0] PAUSE_CNT = CNT_W'(PAUSE_LEN);

    parse_state_e     state_q;
    logic [CNT_W-1:0] skip_cnt_q;
    logic             lshift_q;
    logic             rshift_q;
    logic             caps_q;
    logic             caps_held_q;
    logic             overflow_q;

    logic             byte_ok;
    logic             is_status;
    logic             emit_d;
    evt_t             evt_d;
    logic [EVT_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    assign byte_ok   = rx_valid && !rx_err;
    assign is_status = (rx_byte == SC_AA) || (rx_byte == SC_FA) ||
                       (rx_byte == SC_FE) || (rx_byte == SC_EE) ||
                       (rx_byte == SC_00) || (rx_byte == SC_FF);

    // Event decode from the current state and byte; written to the FIFO at the
    // edge that ends the cycle carrying the final byte.
    always_comb begin
        emit_d    = 1'b0;
        evt_d     = '0;
        evt_d.code = rx_byte;
        case (state_q)
            ST_IDLE: begin
                emit_d = byte_ok && (rx_byte != SC_E0) && (rx_byte != SC_F0) &&
                         (rx_byte != SC_E1) && !is_status;
            end
            ST_EXT: begin
                emit_d    = byte_ok && (rx_byte != SC_F0);
                evt_d.ext = 1'b1;
            end
            ST_BRK: begin
                emit_d    = byte_ok;
                evt_d.brk = 1'b1;
            end
            ST_EXT_BRK: begin
                emit_d    = byte_ok;
                evt_d.ext = 1'b1;
                evt_d.brk = 1'b1;
            end
            default: emit_d = 1'b0;
        endcase
        // ASCII sees the modifier state from before this byte.
        evt_d.ascii = scan_to_ascii(rx_byte, evt_d.ext,
                                    (lshift_q || rshift_q) ^ caps_q);
    end

    // Parser state, Pause skip counter and modifier tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else if (rx_err) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_E0) begin
                        state_q <= ST_EXT;
                    end else if (rx_byte == SC_F0) begin
                        state_q <= ST_BRK;
                    end else if (rx_byte == SC_E1 && PAUSE_LEN != 0) begin
                        state_q    <= ST_SKIP;
                        skip_cnt_q <= PAUSE_CNT;
                    end
                end
                ST_EXT: begin
                    state_q <= (rx_byte == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_SKIP: begin
                    skip_cnt_q <= skip_cnt_q - 1'b1;
                    if (skip_cnt_q <= 1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (emit_d && !evt_d.ext) begin
                if (rx_byte == SC_LSHIFT) begin
                    lshift_q <= !evt_d.brk;
                end
                if (rx_byte == SC_RSHIFT) begin
                    rshift_q <= !evt_d.brk;
                end
                // Typematic repeats of the Caps make must not re-toggle.
                if (rx_byte == SC_CAPS) begin
                    if (evt_d.brk) begin
                        caps_held_q <= 1'b0;
                    end else begin
                        if (!caps_held_q) begin
                            caps_q <= !caps_q;
                        end
                        caps_held_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign pop  = !fifo_empty && evt_ready;
    assign drop = emit_d && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (emit_d),
        .din_i   (evt_d),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid    = !fifo_empty;
    assign evt_ext      = head[EVT_EXT_BIT];
    assign evt_break    = head[EVT_BRK_BIT];
    assign evt_code     = head[EVT_CODE_LSB +: 8];
    assign evt_ascii    = head[EVT_ASCII_LSB +: 8];
    assign shift_active = lshift_q || rshift_q;
    assign caps_lock    = caps_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Downstream consumer of the PS/2 frame receiver. Takes validated scan-code bytes (set 2) and collapses the E0/F0/E1 prefix sequences into single key events (code, extended, break). Tracks Shift and Caps Lock, translates to ASCII and buffers events in a small FIFO with a valid/ready handshake toward UART/display logic.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, min 2
PAUSE_LEN, 7, bytes following E1 that are discarded (Pause key)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, asynchronous, active-low
rx_byte  in  8  received scan-code byte; qualified by rx_valid
rx_valid  in  1  one-cycle strobe, byte passed parity/stop check
rx_err  in  1  one-cycle strobe, frame error in receiver
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_code  out  8  scan code without prefixes
evt_ext  out  1  event was E0-prefixed
evt_break  out  1  1 = release, 0 = press
evt_ascii  out  8  ASCII of key, 8'h00 if none
shift_active  out  1  left or right Shift held
caps_lock  out  1  Caps Lock toggle state
overflow  out  1  sticky: event dropped on full FIFO
ovf_clr  in  1  clears overflow

Behaviour:
- Reset: all outputs 0, FIFO empty, parser in IDLE, internal caps_held 0.
- Parser states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (E0 F0), SKIP (E1 stream).
- Bytes act only on rx_valid. IDLE: E0->EXT; F0->BRK; E1->SKIP with counter=PAUSE_LEN; AA, FA, FE, EE, 00, FF discarded (status/ack/error), stay IDLE; other byte -> emit event ext=0 brk=0.
- EXT: F0->EXT_BRK; other -> emit ext=1 brk=0, IDLE. BRK: emit ext=0 brk=1, IDLE. EXT_BRK: emit ext=1 brk=1, IDLE.
- SKIP: each byte decrements counter; at last byte -> IDLE; no events, no modifier change.
- rx_err in any state: return to IDLE, drop partial prefix; same-cycle rx_valid ignored.
- Modifiers (non-extended only): 12/59 make sets the respective held bit, break clears; shift_active = OR. 58 make toggles caps_lock only if caps_held=0, then sets caps_held; 58 break clears caps_held (typematic repeat does not re-toggle).
- ASCII uses modifier state before the current byte. Letters (1C A,32 B,21 C,23 D,24 E,2B F,34 G,33 H,43 I,3B J,42 K,4B L,3A M,31 N,44 O,4D P,15 Q,2D R,1B S,2C T,3C U,2A V,1D W,22 X,35 Y,1A Z): uppercase if shift_active XOR caps_lock, else lowercase. Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9' regardless of shift. 29->20, 5A->0D, 66->08, 0D->09, 76->1B. All else and all ext=1 -> 00. Break events carry the same ASCII.
- Latency: final byte's rx_valid in cycle N -> event written at edge ending N; evt_valid high in N+1 if FIFO was empty. Modifier outputs update at the same edge.
- FIFO: first-word-fall-through; pop when evt_valid & evt_ready. Full and push without pop -> event dropped, overflow set. Full with simultaneous push+pop -> both succeed. Empty: evt_ready ignored, outputs hold last values.
- overflow: set on drop, cleared by ovf_clr; simultaneous set and clear -> stays set.
- Modifier events are still emitted to the FIFO.

Decomposition:
- ps2_pkg: byte constants (E0, F0, E1, AA, FA, FE, EE), modifier codes (12, 59, 58), event field widths/offsets (18-bit entry {ext,brk,code,ascii}).
- Sub-module ps2_evt_fifo: parameterised FWFT FIFO with push/pop/full/empty; parser, modifiers and ASCII table stay in the top.

Test Plan:
- Reset, evt_ready=1, send 1C -> one event code=1C ext=0 brk=0 ascii=61, evt_valid in cycle after strobe.
- Send 12, 1C, F0 1C, F0 12 -> events 12/00, 1C/41, 1C brk=1 ascii=41, 12 brk=1; shift_active 1 then 0.
- Send 58, 58, F0 58, then 1C -> caps_lock=1 after first 58 only; 1C ascii=41.
- Send E0 75, E0 F0 75 -> events code=75 ext=1 brk=0 ascii=00, then ext=1 brk=1.
- Send E1 14 77 E1 F0 14 F0 77 then 29 -> only one event 29/20; send E0 then rx_err then 1C -> event ext=0.
- evt_ready=0, send 5 make codes with FIFO_DEPTH=4 -> 4 events kept in order, overflow=1; pulse ovf_clr -> 0; full with push+pop same cycle -> no drop.
